// File: rtl/vend_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module   : vend_ctrl_gen
// Brief    : Cart-based vending transaction controller with coin collection,
//            inactivity refund and greedy change over a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module vend_ctrl_gen #(
  parameter int MONEY_W     = 8,
  parameter int PRICE_W     = 6,
  parameter int QTY_W       = 2,
  parameter int CART_DEPTH  = 2,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst_n,
  input  logic                            sys_Goods,
  input  logic                            sys_Confirm,
  input  logic                            sys_Change,
  input  logic                            sys_Cancel,
  input  logic [4:0]                      coin_in,
  input  logic [PRICE_W-1:0]              item_price,
  input  logic [QTY_W-1:0]                item_qty,
  input  logic                            chg_ready,
  output logic [2:0]                      state_out,
  output logic [MONEY_W-1:0]              need_money_out,
  output logic [MONEY_W-1:0]              input_money_out,
  output logic [MONEY_W-1:0]              change_money_out,
  output logic [$clog2(CART_DEPTH+1)-1:0] cart_cnt_out,
  output logic                            chg_valid,
  output logic [4:0]                      chg_coin,
  output logic                            vend_done,
  output logic                            err_pulse
);

  localparam int c_CNT_W = $clog2(CART_DEPTH + 1);
  localparam int c_TMR_W = $clog2(TIMEOUT_CYC);
  // Wide enough for money + coin sum and for need + price*qty without wrap
  localparam int c_ACC_W = MONEY_W + PRICE_W + QTY_W + 1;

  localparam logic [c_ACC_W-1:0] c_MONEY_MAX = {{(c_ACC_W-MONEY_W){1'b0}}, {MONEY_W{1'b1}}};
  localparam logic [c_CNT_W-1:0] c_CART_MAX  = c_CNT_W'(CART_DEPTH);
  localparam logic [c_TMR_W-1:0] c_TMR_LAST  = c_TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_PAY    = 3'd2,
    ST_PAID   = 3'd3,
    ST_CHANGE = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t               r_state;
  logic [MONEY_W-1:0]   r_need;
  logic [MONEY_W-1:0]   r_input;
  logic [MONEY_W-1:0]   r_change;
  logic [c_CNT_W-1:0]   r_cart_cnt;
  logic [c_TMR_W-1:0]   r_timer;
  logic                 r_is_refund;
  logic                 r_chg_valid;
  logic [4:0]           r_chg_coin;
  logic                 r_vend_done;
  logic                 r_err_pulse;

  logic [c_ACC_W-1:0]   w_coin_val;
  logic [c_ACC_W-1:0]   w_input_sum;
  logic [c_ACC_W-1:0]   w_item_cost;
  logic [c_ACC_W-1:0]   w_need_sum;
  logic [MONEY_W-1:0]   w_input_sat;
  logic [MONEY_W-1:0]   w_paid_change;
  logic [MONEY_W-1:0]   w_chg_rem;
  logic [4:0]           w_refund_coin;
  logic [4:0]           w_paid_coin;
  logic [4:0]           w_rem_coin;
  logic                 w_goods_ok;
  logic                 w_idle_tmo;
  logic                 w_chg_exit;

  function automatic logic [c_ACC_W-1:0] f_coin_sum(input logic [4:0] coins);
    logic [c_ACC_W-1:0] sum;
    sum = '0;
    if (coins[0]) sum = sum + c_ACC_W'(1);
    if (coins[1]) sum = sum + c_ACC_W'(5);
    if (coins[2]) sum = sum + c_ACC_W'(10);
    if (coins[3]) sum = sum + c_ACC_W'(20);
    if (coins[4]) sum = sum + c_ACC_W'(50);
    return sum;
  endfunction

  function automatic logic [MONEY_W-1:0] f_denom(input logic [4:0] coin);
    logic [MONEY_W-1:0] val;
    case (coin)
      5'b00001: val = MONEY_W'(1);
      5'b00010: val = MONEY_W'(5);
      5'b00100: val = MONEY_W'(10);
      5'b01000: val = MONEY_W'(20);
      5'b10000: val = MONEY_W'(50);
      default:  val = '0;
    endcase
    return val;
  endfunction

  // Largest denomination not exceeding the amount; zero amount gives no coin
  function automatic logic [4:0] f_greedy(input logic [MONEY_W-1:0] amt);
    logic [c_ACC_W-1:0] a;
    logic [4:0]         coin;
    a = c_ACC_W'(amt);
    if (a >= c_ACC_W'(50))      coin = 5'b10000;
    else if (a >= c_ACC_W'(20)) coin = 5'b01000;
    else if (a >= c_ACC_W'(10)) coin = 5'b00100;
    else if (a >= c_ACC_W'(5))  coin = 5'b00010;
    else if (a >= c_ACC_W'(1))  coin = 5'b00001;
    else                        coin = 5'b00000;
    return coin;
  endfunction

  assign w_coin_val    = f_coin_sum(coin_in);
  assign w_input_sum   = c_ACC_W'(r_input) + w_coin_val;
  assign w_input_sat   = (w_input_sum > c_MONEY_MAX) ? {MONEY_W{1'b1}} : w_input_sum[MONEY_W-1:0];
  assign w_item_cost   = c_ACC_W'(item_price) * c_ACC_W'(item_qty);
  assign w_need_sum    = c_ACC_W'(r_need) + w_item_cost;
  assign w_goods_ok    = (item_qty != '0) && (r_cart_cnt < c_CART_MAX) && (w_need_sum <= c_MONEY_MAX);
  assign w_paid_change = w_input_sat - r_need;
  assign w_chg_rem     = r_change - f_denom(r_chg_coin);
  assign w_refund_coin = f_greedy(w_input_sat);
  assign w_paid_coin   = f_greedy(w_paid_change);
  assign w_rem_coin    = f_greedy(w_chg_rem);
  assign w_idle_tmo    = (coin_in == 5'b00000) && (r_timer == c_TMR_LAST);
  assign w_chg_exit    = !r_chg_valid || (chg_ready && (w_chg_rem == '0));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= ST_IDLE;
      r_need      <= '0;
      r_input     <= '0;
      r_change    <= '0;
      r_cart_cnt  <= '0;
      r_timer     <= '0;
      r_is_refund <= 1'b0;
      r_chg_valid <= 1'b0;
      r_chg_coin  <= 5'b00000;
      r_vend_done <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_vend_done <= 1'b0;
      r_err_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!sys_Cancel && sys_Confirm) r_state <= ST_SELECT;
        end

        ST_SELECT: begin
          if (sys_Cancel) begin
            r_state    <= ST_IDLE;
            r_need     <= '0;
            r_cart_cnt <= '0;
          end else if (sys_Confirm) begin
            if (r_cart_cnt != '0) begin
              r_state <= ST_PAY;
              r_timer <= '0;
            end
          end else if (!sys_Change && sys_Goods) begin
            if (w_goods_ok) begin
              r_need     <= w_need_sum[MONEY_W-1:0];
              r_cart_cnt <= r_cart_cnt + c_CNT_W'(1);
            end else begin
              r_err_pulse <= 1'b1;
            end
          end
        end

        ST_PAY: begin
          r_input <= w_input_sat;
          r_timer <= (coin_in != 5'b00000) ? '0 : r_timer + c_TMR_W'(1);
          // Payment completion is judged on the registered total, so it lands one cycle after the coin
          if (sys_Cancel || ((r_input < r_need) && w_idle_tmo)) begin
            r_state     <= ST_CHANGE;
            r_change    <= w_input_sat;
            r_need      <= '0;
            r_is_refund <= 1'b1;
            r_chg_coin  <= w_refund_coin;
            r_chg_valid <= (w_input_sat != '0);
            r_timer     <= '0;
          end else if (r_input >= r_need) begin
            r_state <= ST_PAID;
            r_timer <= '0;
          end
        end

        ST_PAID: begin
          r_input <= w_input_sat;
          if (sys_Cancel) begin
            r_state     <= ST_CHANGE;
            r_change    <= w_input_sat;
            r_need      <= '0;
            r_is_refund <= 1'b1;
            r_chg_coin  <= w_refund_coin;
            r_chg_valid <= (w_input_sat != '0);
          end else if (sys_Change) begin
            r_change    <= w_paid_change;
            r_is_refund <= 1'b0;
            if (w_paid_change == '0) begin
              r_state     <= ST_DONE;
              r_vend_done <= 1'b1;
            end else begin
              r_state     <= ST_CHANGE;
              r_chg_coin  <= w_paid_coin;
              r_chg_valid <= 1'b1;
            end
          end
        end

        ST_CHANGE: begin
          if (r_chg_valid && chg_ready) begin
            r_change    <= w_chg_rem;
            r_chg_coin  <= w_rem_coin;
            r_chg_valid <= (w_chg_rem != '0);
          end
          if (w_chg_exit) begin
            if (r_is_refund) begin
              r_state     <= ST_IDLE;
              r_need      <= '0;
              r_input     <= '0;
              r_change    <= '0;
              r_cart_cnt  <= '0;
              r_is_refund <= 1'b0;
            end else begin
              r_state     <= ST_DONE;
              r_vend_done <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_need      <= '0;
          r_input     <= '0;
          r_change    <= '0;
          r_cart_cnt  <= '0;
          r_timer     <= '0;
          r_is_refund <= 1'b0;
        end

        default: begin
          r_state     <= ST_IDLE;
          r_need      <= '0;
          r_input     <= '0;
          r_change    <= '0;
          r_cart_cnt  <= '0;
          r_timer     <= '0;
          r_is_refund <= 1'b0;
          r_chg_valid <= 1'b0;
          r_chg_coin  <= 5'b00000;
        end
      endcase
    end
  end

  assign state_out        = r_state;
  assign need_money_out   = r_need;
  assign input_money_out  = r_input;
  assign change_money_out = r_change;
  assign cart_cnt_out     = r_cart_cnt;
  assign chg_valid        = r_chg_valid;
  assign chg_coin         = r_chg_coin;
  assign vend_done        = r_vend_done;
  assign err_pulse        = r_err_pulse;

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_ctrl_gen
// Brief    : Directed plus random stimulus against a transaction-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_vend_ctrl_gen;

  localparam int MONEY_W     = 8;
  localparam int PRICE_W     = 6;
  localparam int QTY_W       = 2;
  localparam int CART_DEPTH  = 2;
  localparam int TIMEOUT_CYC = 20;
  localparam int MONEY_MAX   = (1 << MONEY_W) - 1;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst_n;
  logic                 sys_Goods, sys_Confirm, sys_Change, sys_Cancel;
  logic [4:0]           coin_in;
  logic [PRICE_W-1:0]   item_price;
  logic [QTY_W-1:0]     item_qty;
  logic                 chg_ready;
  logic [2:0]           state_out;
  logic [MONEY_W-1:0]   need_money_out, input_money_out, change_money_out;
  logic [1:0]           cart_cnt_out;
  logic                 chg_valid;
  logic [4:0]           chg_coin;
  logic                 vend_done, err_pulse;

  vend_ctrl_gen #(
    .MONEY_W(MONEY_W), .PRICE_W(PRICE_W), .QTY_W(QTY_W),
    .CART_DEPTH(CART_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .sys_Goods(sys_Goods), .sys_Confirm(sys_Confirm),
    .sys_Change(sys_Change), .sys_Cancel(sys_Cancel),
    .coin_in(coin_in), .item_price(item_price), .item_qty(item_qty),
    .chg_ready(chg_ready), .state_out(state_out),
    .need_money_out(need_money_out), .input_money_out(input_money_out),
    .change_money_out(change_money_out), .cart_cnt_out(cart_cnt_out),
    .chg_valid(chg_valid), .chg_coin(chg_coin),
    .vend_done(vend_done), .err_pulse(err_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level reference: plain integers, states as the documented codes
  int m_st, m_need, m_input, m_change, m_cart, m_idle;
  bit m_refund, m_vend, m_err;

  function automatic int denom(input int b);
    case (b)
      0: return 1;
      1: return 5;
      2: return 10;
      3: return 20;
      default: return 50;
    endcase
  endfunction

  function automatic int greedy_bit(input int amt);
    for (int b = 4; b >= 0; b--) if (denom(b) <= amt) return b;
    return -1;
  endfunction

  task automatic model_reset();
    m_st = 0; m_need = 0; m_input = 0; m_change = 0; m_cart = 0;
    m_idle = 0; m_refund = 0; m_vend = 0; m_err = 0;
  endtask

  task automatic model_clear();
    m_need = 0; m_input = 0; m_change = 0; m_cart = 0; m_refund = 0;
  endtask

  task automatic model_refund();
    m_change = m_input; m_need = 0; m_refund = 1; m_st = 4;
  endtask

  task automatic model_finish_change();
    if (m_refund) begin model_clear(); m_st = 0; end
    else begin m_st = 5; m_vend = 1; end
  endtask

  task automatic model_step();
    int csum, cost, d, old_in;
    csum = 0;
    for (int b = 0; b < 5; b++) if (coin_in[b]) csum += denom(b);
    m_vend = 0; m_err = 0;
    case (m_st)
      0: if (!sys_Cancel && sys_Confirm) m_st = 1;
      1: begin
        if (sys_Cancel) begin m_st = 0; m_need = 0; m_cart = 0; end
        else if (sys_Confirm) begin
          if (m_cart > 0) begin m_st = 2; m_idle = 0; end
        end else if (!sys_Change && sys_Goods) begin
          cost = int'(item_price) * int'(item_qty);
          if (item_qty != 0 && m_cart < CART_DEPTH && m_need + cost <= MONEY_MAX) begin
            m_need += cost; m_cart++;
          end else m_err = 1;
        end
      end
      2: begin
        old_in  = m_input;
        m_input = (m_input + csum > MONEY_MAX) ? MONEY_MAX : m_input + csum;
        m_idle  = (csum != 0) ? 0 : m_idle + 1;
        if (sys_Cancel) model_refund();
        else if (old_in >= m_need) m_st = 3;
        else if (m_idle == TIMEOUT_CYC) model_refund();
      end
      3: begin
        m_input = (m_input + csum > MONEY_MAX) ? MONEY_MAX : m_input + csum;
        if (sys_Cancel) model_refund();
        else if (sys_Change) begin
          d = m_input - m_need;
          m_change = d; m_refund = 0;
          if (d == 0) begin m_st = 5; m_vend = 1; end
          else m_st = 4;
        end
      end
      4: begin
        if (m_change == 0) model_finish_change();
        else if (chg_ready) begin
          m_change -= denom(greedy_bit(m_change));
          if (m_change == 0) model_finish_change();
        end
      end
      5: begin model_clear(); m_st = 0; end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    int exp_coin;
    exp_coin = (m_st == 4 && m_change > 0) ? (1 << greedy_bit(m_change)) : 0;
    chk("state", int'(state_out), m_st);
    chk("need", int'(need_money_out), m_need);
    chk("input", int'(input_money_out), m_input);
    chk("change", int'(change_money_out), m_change);
    chk("cart_cnt", int'(cart_cnt_out), m_cart);
    chk("chg_valid", int'(chg_valid), (m_st == 4 && m_change > 0) ? 1 : 0);
    chk("chg_coin", int'(chg_coin), exp_coin);
    chk("vend_done", int'(vend_done), int'(m_vend));
    chk("err_pulse", int'(err_pulse), int'(m_err));
  endtask

  task automatic cyc(input logic g, input logic cf, input logic ch, input logic cn,
                     input logic [4:0] c, input logic rdy);
    sys_Goods = g; sys_Confirm = cf; sys_Change = ch; sys_Cancel = cn;
    coin_in = c; chg_ready = rdy;
    model_step();
    @(posedge sys_clk);
    #1;
    compare_all();
    sys_Goods = 0; sys_Confirm = 0; sys_Change = 0; sys_Cancel = 0; coin_in = 0;
  endtask

  task automatic goods(input int p, input int q);
    item_price = PRICE_W'(p); item_qty = QTY_W'(q);
    cyc(1, 0, 0, 0, 5'b0, 1);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 5'b0, rdy);
  endtask

  task automatic async_reset_check();
    #2;
    sys_rst_n = 0;
    #1;
    model_reset();
    chk("rst_state", int'(state_out), 0);
    chk("rst_input", int'(input_money_out), 0);
    chk("rst_change", int'(change_money_out), 0);
    chk("rst_chg_valid", int'(chg_valid), 0);
    chk("rst_chg_coin", int'(chg_coin), 0);
    compare_all();
    @(negedge sys_clk);
    sys_rst_n = 1;
  endtask

  logic       r_g, r_cf, r_ch, r_cn, r_rdy;
  logic [4:0] r_c;

  initial begin
    sys_rst_n = 0;
    sys_Goods = 0; sys_Confirm = 0; sys_Change = 0; sys_Cancel = 0;
    coin_in = 0; item_price = 0; item_qty = 0; chg_ready = 0;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    compare_all();
    @(negedge sys_clk);
    sys_rst_n = 1;

    // Purchase with change, cart full rejection
    cyc(0, 1, 0, 0, 5'b0, 0);
    goods(3, 2);
    goods(5, 1);
    chk("plan_need", int'(need_money_out), 11);
    chk("plan_cart", int'(cart_cnt_out), 2);
    goods(1, 1);
    chk("cart_full_err", int'(err_pulse), 1);
    chk("cart_full_need", int'(need_money_out), 11);
    cyc(0, 1, 0, 0, 5'b0, 0);
    cyc(0, 0, 0, 0, 5'b00100, 0);
    cyc(0, 0, 0, 0, 5'b00010, 0);
    chk("plan_input", int'(input_money_out), 15);
    idle(1, 0);
    chk("plan_paid", int'(state_out), 3);
    cyc(0, 0, 1, 0, 5'b0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("plan_coin1", int'(chg_coin), 1);
      cyc(0, 0, 0, 0, 5'b0, 1);
    end
    chk("plan_vend", int'(vend_done), 1);
    idle(1, 1);

    // Overflow rejection, all-coin cycle, cancel refund interrupted by reset
    cyc(0, 1, 0, 0, 5'b0, 0);
    goods(63, 3);
    goods(63, 3);
    chk("ovf_err", int'(err_pulse), 1);
    chk("ovf_need", int'(need_money_out), 189);
    cyc(0, 1, 0, 0, 5'b0, 0);
    cyc(0, 0, 0, 0, 5'b11111, 0);
    chk("all_coins", int'(input_money_out), 86);
    cyc(0, 0, 0, 1, 5'b0, 0);
    chk("refund_amt", int'(change_money_out), 86);
    cyc(0, 0, 0, 0, 5'b0, 1);
    cyc(0, 0, 0, 0, 5'b0, 0);
    async_reset_check();

    // Inactivity timeout refund
    cyc(0, 1, 0, 0, 5'b0, 0);
    goods(30, 1);
    cyc(0, 1, 0, 0, 5'b0, 0);
    cyc(0, 0, 0, 0, 5'b01000, 0);
    idle(TIMEOUT_CYC - 1, 0);
    chk("tmo_still_pay", int'(state_out), 2);
    idle(1, 0);
    chk("tmo_change", int'(change_money_out), 20);
    chk("tmo_coin", int'(chg_coin), 8);
    cyc(0, 0, 0, 0, 5'b0, 1);
    chk("tmo_idle", int'(state_out), 0);
    chk("tmo_no_vend", int'(vend_done), 0);

    // Handshake stall on change of 35
    cyc(0, 1, 0, 0, 5'b0, 0);
    goods(5, 1);
    cyc(0, 1, 0, 0, 5'b0, 0);
    cyc(0, 0, 0, 0, 5'b01000, 0);
    cyc(0, 0, 0, 0, 5'b01000, 0);
    idle(1, 0);
    cyc(0, 0, 1, 0, 5'b0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_coin", int'(chg_coin), 8);
      chk("stall_change", int'(change_money_out), 35);
      cyc(0, 0, 0, 0, 5'b0, 0);
    end
    cyc(0, 0, 0, 0, 5'b0, 1);
    chk("stall_coin10", int'(chg_coin), 4);
    cyc(0, 0, 0, 0, 5'b0, 1);
    chk("stall_coin5", int'(chg_coin), 2);
    cyc(0, 0, 0, 0, 5'b0, 1);
    chk("stall_vend", int'(vend_done), 1);
    idle(1, 0);

    // Cancel beats Confirm in SELECT
    cyc(0, 1, 0, 0, 5'b0, 0);
    goods(2, 1);
    cyc(0, 1, 0, 1, 5'b0, 0);
    chk("cancel_confirm", int'(state_out), 0);
    chk("cancel_cart", int'(cart_cnt_out), 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      r_g   = ($urandom_range(0, 99) < 25);
      r_cf  = ($urandom_range(0, 99) < 12);
      r_ch  = ($urandom_range(0, 99) < 10);
      r_cn  = ($urandom_range(0, 99) < 3);
      r_rdy = ($urandom_range(0, 99) < 60);
      r_c   = ($urandom_range(0, 99) < 15) ? 5'($urandom_range(1, 31)) : 5'b0;
      item_price = PRICE_W'($urandom_range(0, 63));
      item_qty   = QTY_W'($urandom_range(0, 3));
      cyc(r_g, r_cf, r_ch, r_cn, r_c, r_rdy);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vend_ctrl_gen.md
# vend_ctrl_gen

Parametrised next-generation vending transaction controller for the FPGA micro-vending machine. It accumulates a multi-entry cart of up to CART_DEPTH items, collects coins on five denomination channels, and auto-refunds on cancel or inactivity timeout. It dispenses change one coin at a time over a valid/ready handshake, using a greedy algorithm. It sits between the debounced button/switch front end and the display/dispenser back end, and exposes its money buffers for the seven-segment driver.

## Interface
- MONEY_W, 8: width of all money accumulators (yuan).
- PRICE_W, 6: width of unit price input.
- QTY_W, 2: width of quantity input.
- CART_DEPTH, 2: maximum cart entries per transaction (≥1).
- TIMEOUT_CYC, 1000: idle cycles in PAY before auto-refund (≥2).

- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset; asynchronous and active-low.
- sys_Goods  in  1  one-cycle pulse: add current item to cart.
- sys_Confirm  in  1  one-cycle pulse: start session / close cart.
- sys_Change  in  1  one-cycle pulse: request change after full payment.
- sys_Cancel  in  1  one-cycle pulse: abort and refund.
- coin_in  in  5  one-cycle coin pulses. Bit0=1, bit1=5, bit2=10, bit3=20, bit4=50.
- item_price  in  PRICE_W  unit price of selected item (external lookup).
- item_qty  in  QTY_W  quantity of selected item.
- chg_ready  in  1  dispenser accepts chg_coin this cycle.
- state_out  out  3  current state encoding.
- need_money_out  out  MONEY_W  cart total.
- input_money_out  out  MONEY_W  money inserted.
- change_money_out  out  MONEY_W  change still to dispense.
- cart_cnt_out  out  $clog2(CART_DEPTH+1)  cart entries held.
- chg_valid  out  1  chg_coin is valid.
- chg_coin  out  5  one-hot denomination being dispensed (same bit map as coin_in).
- vend_done  out  1  one-cycle pulse: goods released.
- err_pulse  out  1  one-cycle pulse: rejected Goods entry.

## Operation
- States: IDLE=0, SELECT=1, PAY=2, PAID=3, CHANGE=4, DONE=5. Others decode to IDLE.
- Inputs are sampled at the clock edge. When several inputs are asserted together, priority is Cancel > Confirm > Change > Goods. Coins are processed independently of buttons.
- IDLE: all buffers are 0. Confirm moves to SELECT. All other inputs are ignored.
- SELECT:
  - Goods with qty≠0 and cart_cnt<CART_DEPTH and need+price*qty ≤ 2^MONEY_W−1: need += price*qty, cart_cnt++.
  - Goods that fails any of those conditions: err_pulse=1 and nothing else changes.
  - Confirm with cart_cnt>0 moves to PAY. Confirm with cart_cnt=0 is ignored.
  - Cancel moves to IDLE and clears the cart. Coins are ignored in SELECT.
- PAY:
  - In each cycle, input += sum of asserted coin_in values, saturating at 2^MONEY_W−1. Each coin cycle reloads the timeout counter.
  - When the registered input ≥ need, the block moves to PAID.
  - Cancel, or TIMEOUT_CYC consecutive cycles with no coin: change = input, need = 0, move to CHANGE. This is a refund, and no vend_done is issued.
- PAID: further coins keep accumulating and saturating.
  - Change: change = input − need, then CHANGE. If the result is 0, go straight to DONE.
  - Cancel: full refund as in PAY.
- CHANGE:
  - chg_valid=1 while change>0. chg_coin is the largest denomination ≤ change.
  - On chg_valid&chg_ready: change −= denomination, and a new coin is presented next cycle.
  - When change reaches 0: go to DONE if this was a purchase, or to IDLE if it was a refund.
  - Buttons and coins are ignored in CHANGE.
- DONE: vend_done=1 for one cycle, then IDLE with all buffers cleared.

## Timing
- Reset values: state IDLE, every money buffer 0, cart_cnt 0, chg_valid 0, chg_coin 0, vend_done 0, err_pulse 0, timeout counter cleared. Reset asserted mid-transaction aborts immediately with no refund.
- All outputs are registered, so each input takes effect with one cycle of latency.
- The PAY→PAID transition happens the cycle after the coin that completes payment.
- chg_coin and change_money_out are stable while chg_valid=1 and chg_ready=0.
- Dispensing throughput is at most one coin per cycle.
- The timeout counter runs only in PAY. It resets on state entry and on each coin cycle. Auto-refund fires on the TIMEOUT_CYC-th idle cycle.

## Test plan
- Purchase with change:
  - Confirm, price=3 qty=2 Goods, price=5 qty=1 Goods, Confirm: need=11, cart_cnt=2.
  - Coins 10 then 5: input=15, PAID. Change: coins 1,1,1,1 dispensed, then vend_done.
- Cart full: with CART_DEPTH=2, a third Goods gives err_pulse=1 and need stays 11.
- Overflow: price=63 qty=3 twice (need would be 378 > 255) gives err_pulse and no change to need.
- Timeout: in PAY with input=20, no coins for TIMEOUT_CYC cycles. A refund of one 20 coin follows, then IDLE with no vend_done.
- Handshake stall: change=35 with chg_ready held low 5 cycles. chg_coin stays 20 (one-hot 01000). Then 10 and 5 are dispensed.
- Simultaneous events:
  - coin_in=11111 in one cycle adds 86.
  - Cancel together with Confirm in SELECT leads to IDLE.
  - Reset during CHANGE clears all outputs asynchronously.
